muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide, IDLE-CALC-FIX.
// Optional feature macro: MULDIV_ZERO_SKIP_EN (multiply by zero skips CALC).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               div_q, div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               skip_q, skip_d;
    logic               skdz_q, skdz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sgn, a_neg, b_neg, by_zero, mul_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes and early-exit detection at acceptance
    always_comb begin
        sgn     = ~op[0];
        a_neg   = sgn & a[WIDTH-1];
        b_neg   = sgn & b[WIDTH-1];
        mag_a   = a_neg ? -a : a;
        mag_b   = b_neg ? -b : b;
        by_zero = op[1] & (b == '0);
`ifdef MULDIV_ZERO_SKIP_EN
        mul_zero = ~op[1] & ((a == '0) | (b == '0));
`else
        mul_zero = 1'b0;
`endif
    end

    // One radix-2 step for each operation, plus the sign-corrected product
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, dvs_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        prod_fix  = negq_q ? -acc_q : acc_q;
    end

    // FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        skip_d  = skip_q;
        skdz_d  = skdz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    div_d   = op[1];
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    skip_d  = by_zero | mul_zero;
                    skdz_d  = by_zero;
                    dz_d    = 1'b0;
                    // Multiply: upper=partial product, lower=multiplier.
                    // Divide: upper=remainder, lower=dividend/quotient.
                    acc_d   = op[1] ? {{WIDTH{1'b0}}, mag_a}
                                    : {{WIDTH{1'b0}}, mag_b};
                    dvs_d   = op[1] ? mag_b : mag_a;
                end
            end
            S_CALC: begin
                if (skip_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (skdz_q) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d = '0;
                        lo_d = '0;
                    end
                end else begin
                    if (div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = {div_diff[WIDTH-1:0],
                                     acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {div_shift[WIDTH-1:0],
                                     acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    lo_d = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH]
                                  : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            skip_q  <= 1'b0;
            skdz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            skip_q  <= skip_d;
            skdz_q  <= skdz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random + directed scoreboard bench for muldiv_unit.
// Reference model uses plain 64-bit arithmetic.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t         sq[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] hold_hi = '0;
    logic [W-1:0] hold_lo = '0;
    logic         prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // Reference result from the arithmetic definition of each op
    task automatic model(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output exp_t e);
        longint          sp, sq_, sr;
        longint unsigned up;
        int              lat;
        lat  = W + 1;
        e.dz = 1'b0;
        case (o)
            2'd0: begin
                sp   = longint'($signed(x)) * longint'($signed(y));
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'd1: begin
                up   = {32'd0, x} * {32'd0, y};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'd2: begin
                if (y == 0) begin
                    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; lat = 1;
                end else begin
                    sq_  = longint'($signed(x)) / longint'($signed(y));
                    sr   = longint'($signed(x)) % longint'($signed(y));
                    e.hi = sr[31:0];
                    e.lo = sq_[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; lat = 1;
                end else begin
                    e.hi = x % y;
                    e.lo = x / y;
                end
            end
        endcase
`ifdef MULDIV_ZERO_SKIP_EN
        if (!o[1] && (x == 0 || y == 0)) lat = 1;
`endif
        e.cyc = cyc + 1 + lat;
        m_hi  = e.hi;
        m_lo  = e.lo;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy still %b, expected 0", busy);
        end
    endtask

    // Drive one request at a negedge; returns just after its accept edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        exp_t e;
        wait_idle();
        model(o, x, y, e);
        sq.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sq.size());
            sq.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: pop and compare on each done, watch holds and pulse width
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                chk("done_twice", 64'(done & prev_done), 64'd0);
                if (sq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: got done, expected none");
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    hold_hi = e.hi;
                    hold_lo = e.lo;
                end
            end else begin
                chk("hold_hi", 64'(hi), 64'(hold_hi));
                chk("hold_lo", 64'(lo), 64'(hold_lo));
            end
        end
        prev_done = done;
    end

    initial begin
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
        chk("busy_after_e0", 64'(busy), 64'd1);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;

        issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        issue(2'd3, 32'd100, 32'd7);
        issue(2'd3, 32'd100, 32'd0);
        issue(2'd1, 32'd3, 32'd4);
        chk("dz_cleared", 64'(div_zero), 64'd0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd0, 32'h0, 32'h1234);
        issue(2'd1, 32'h5, 32'h0);
        drain();

        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        sq.delete();
        m_hi = '0; m_lo = '0;
        hold_hi = '0; hold_lo = '0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_hold", {busy, done, div_zero}, 64'd0);
        reset = 1'b1;
        issue(2'd0, 32'd6, 32'd7);
        drain();

        for (int i = 0; i < 250; i++) begin
            logic [1:0] o;
            o = 2'($urandom);
            if (o[1] && $urandom_range(0, 5) == 0)
                issue(o, pick(), 32'h0);
            else
                issue(o, pick(), pick());
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
